// File: rtl/id_ex_hazard_stage_if.sv
// Decoder-to-EX bundle for the ID/EX hazard stage: decoded control word, register
// fields, flush request, registered EX control word, write enables and event counters.
interface id_ex_hazard_stage_if #(
  parameter int CNT_W = 16
);
  logic             id_reg_dst;
  logic             id_alu_src;
  logic             id_mem_to_reg;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_branch;
  logic             id_jump;
  logic [1:0]       id_alu_op;
  logic             id_nop;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             flush;

  logic             ex_reg_dst;
  logic             ex_alu_src;
  logic             ex_mem_to_reg;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_branch;
  logic             ex_jump;
  logic [1:0]       ex_alu_op;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump,
           id_alu_op, id_nop, id_rs, id_rt, id_rd, flush,
    input  ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump,
           ex_alu_op, ex_rt, ex_rd, pc_write, ifid_write, ifid_flush,
           stall_count, flush_count
  );

  modport slave (
    input  id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_jump,
           id_alu_op, id_nop, id_rs, id_rt, id_rd, flush,
    output ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump,
           ex_alu_op, ex_rt, ex_rd, pc_write, ifid_write, ifid_flush,
           stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, multi-cycle stall FSM,
// bubble/flush insertion and saturating stall/flush event counters.
module id_ex_hazard_stage #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  id_ex_hazard_stage_if.slave bus
);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  logic       hazard;
  logic       stall;
  logic       bubble;

  // Compare against the load already in EX; a load targeting $0 never creates a dependency.
  assign hazard = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                  ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall = hazard & ~bus.flush;
        if (hazard && !bus.flush && (STALL_CYCLES > 1)) begin
          state_nx = STALL;
          cnt_nx   = 3'(STALL_CYCLES - 2);
        end
      end
      STALL: begin
        // A taken branch/jump makes the stalled instruction dead, so abandon the stall.
        stall = ~bus.flush;
        if (bus.flush || (cnt == 3'd0)) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  assign bubble         = bus.flush | bus.id_nop | stall;
  assign bus.pc_write   = ~stall;
  assign bus.ifid_write = ~stall;
  assign bus.ifid_flush = bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      bus.ex_alu_op     <= 2'b00;
      bus.ex_rt         <= 5'd0;
      bus.ex_rd         <= 5'd0;
    end else if (bubble) begin
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      bus.ex_alu_op     <= 2'b00;
      bus.ex_rt         <= 5'd0;
      bus.ex_rd         <= 5'd0;
    end else begin
      bus.ex_reg_dst    <= bus.id_reg_dst;
      bus.ex_alu_src    <= bus.id_alu_src;
      bus.ex_mem_to_reg <= bus.id_mem_to_reg;
      bus.ex_reg_write  <= bus.id_reg_write;
      bus.ex_mem_read   <= bus.id_mem_read;
      bus.ex_mem_write  <= bus.id_mem_write;
      bus.ex_branch     <= bus.id_branch;
      bus.ex_jump       <= bus.id_jump;
      bus.ex_alu_op     <= bus.id_alu_op;
      bus.ex_rt         <= bus.id_rt;
      bus.ex_rd         <= bus.id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_count <= '0;
    end else if (stall && (bus.stall_count != {CNT_W{1'b1}})) begin
      bus.stall_count <= bus.stall_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flush_count <= '0;
    end else if (bus.flush && (bus.flush_count != {CNT_W{1'b1}})) begin
      bus.flush_count <= bus.flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Drives two stage instances (1-cycle and 3-cycle stall, narrow counters on the second)
// with directed and random decode streams, comparing against a cycle-level reference model.
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic [7:0] ctl;
    logic [1:0] alu_op;
    logic       nop;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       flush;
  } stim_t;

  localparam logic [7:0] CTL_ADDU = 8'b1001_0000;
  localparam logic [7:0] CTL_LW   = 8'b0111_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [19:0] m_ex   [2];
  int          m_rem  [2];
  int          m_scnt [2];
  int          m_fcnt [2];
  int          sc_of  [2] = '{1, 3};
  int          cap_of [2] = '{65535, 15};

  always #5 clk = ~clk;

  id_ex_hazard_stage_if #(.CNT_W(16)) bus_a ();
  id_ex_hazard_stage_if #(.CNT_W(4))  bus_b ();

  id_ex_hazard_stage #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  id_ex_hazard_stage #(.STALL_CYCLES(3), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic [19:0] obs_a;
  logic [19:0] obs_b;
  assign obs_a = {bus_a.ex_reg_dst, bus_a.ex_alu_src, bus_a.ex_mem_to_reg, bus_a.ex_reg_write,
                  bus_a.ex_mem_read, bus_a.ex_mem_write, bus_a.ex_branch, bus_a.ex_jump,
                  bus_a.ex_alu_op, bus_a.ex_rt, bus_a.ex_rd};
  assign obs_b = {bus_b.ex_reg_dst, bus_b.ex_alu_src, bus_b.ex_mem_to_reg, bus_b.ex_reg_write,
                  bus_b.ex_mem_read, bus_b.ex_mem_write, bus_b.ex_branch, bus_b.ex_jump,
                  bus_b.ex_alu_op, bus_b.ex_rt, bus_b.ex_rd};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [7:0] ctl, input logic [1:0] alu_op,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic nop, input logic flush);
    stim_t s;
    s.ctl = ctl; s.alu_op = alu_op; s.rs = rs; s.rt = rt; s.rd = rd; s.nop = nop; s.flush = flush;
    return s;
  endfunction

  task automatic driveBus(input stim_t s);
    {bus_a.id_reg_dst, bus_a.id_alu_src, bus_a.id_mem_to_reg, bus_a.id_reg_write,
     bus_a.id_mem_read, bus_a.id_mem_write, bus_a.id_branch, bus_a.id_jump} = s.ctl;
    {bus_b.id_reg_dst, bus_b.id_alu_src, bus_b.id_mem_to_reg, bus_b.id_reg_write,
     bus_b.id_mem_read, bus_b.id_mem_write, bus_b.id_branch, bus_b.id_jump} = s.ctl;
    bus_a.id_alu_op = s.alu_op; bus_b.id_alu_op = s.alu_op;
    bus_a.id_nop    = s.nop;    bus_b.id_nop    = s.nop;
    bus_a.id_rs     = s.rs;     bus_b.id_rs     = s.rs;
    bus_a.id_rt     = s.rt;     bus_b.id_rt     = s.rt;
    bus_a.id_rd     = s.rd;     bus_b.id_rd     = s.rd;
    bus_a.flush     = s.flush;  bus_b.flush     = s.flush;
  endtask

  task automatic checkRegs();
    checkOutput("ex_word_a", 32'(obs_a), 32'(m_ex[0]));
    checkOutput("ex_word_b", 32'(obs_b), 32'(m_ex[1]));
    checkOutput("stall_count_a", 32'(bus_a.stall_count), 32'(m_scnt[0]));
    checkOutput("stall_count_b", 32'(bus_b.stall_count), 32'(m_scnt[1]));
    checkOutput("flush_count_a", 32'(bus_a.flush_count), 32'(m_fcnt[0]));
    checkOutput("flush_count_b", 32'(bus_b.flush_count), 32'(m_fcnt[1]));
  endtask

  // One ID cycle: model decides whether each instance stalls, then both advance one clock.
  task automatic applyStimulus(input stim_t s);
    bit stl [2];
    driveBus(s);
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [4:0] load_rt;
      bit         hz;
      load_rt = m_ex[k][9:5];
      hz = m_ex[k][15] && (load_rt != 5'd0) && ((load_rt == s.rs) || (load_rt == s.rt));
      stl[k] = !s.flush && ((m_rem[k] > 0) || hz);
      if (s.flush)          m_rem[k] = 0;
      else if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
      else if (hz)          m_rem[k] = sc_of[k] - 1;
    end
    checkOutput("pc_write_a", 32'(bus_a.pc_write), 32'(!stl[0]));
    checkOutput("pc_write_b", 32'(bus_b.pc_write), 32'(!stl[1]));
    checkOutput("ifid_write_a", 32'(bus_a.ifid_write), 32'(!stl[0]));
    checkOutput("ifid_write_b", 32'(bus_b.ifid_write), 32'(!stl[1]));
    checkOutput("ifid_flush_b", 32'(bus_b.ifid_flush), 32'(s.flush));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (s.flush || s.nop || stl[k]) m_ex[k] = '0;
      else                            m_ex[k] = {s.ctl, s.alu_op, s.rt, s.rd};
      if (stl[k] && m_scnt[k] < cap_of[k])  m_scnt[k]++;
      if (s.flush && m_fcnt[k] < cap_of[k]) m_fcnt[k]++;
    end
    @(negedge clk);
    #1;
    checkRegs();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_rem[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
    checkOutput("rst_pc_write_a", 32'(bus_a.pc_write), 32'd1);
    checkOutput("rst_pc_write_b", 32'(bus_b.pc_write), 32'd1);
    checkOutput("rst_ifid_write_b", 32'(bus_b.ifid_write), 32'd1);
    checkRegs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    stim_t s;
    driveBus(mk(8'h00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    doReset();

    applyStimulus(mk(CTL_ADDU, 2'b10, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0));
    checkOutput("rtype_ex_rd", 32'(bus_a.ex_rd), 32'd8);
    checkOutput("rtype_ex_alu_op", 32'(bus_a.ex_alu_op), 32'd2);

    applyStimulus(mk(CTL_LW, 2'b00, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) applyStimulus(mk(CTL_ADDU, 2'b10, 5'd9, 5'd4, 5'd10, 1'b0, 1'b0));
    checkOutput("loaduse_stall_a", 32'(bus_a.stall_count), 32'd1);
    checkOutput("loaduse_stall_b", 32'(bus_b.stall_count), 32'd3);

    applyStimulus(mk(CTL_LW, 2'b00, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0));
    applyStimulus(mk(CTL_ADDU, 2'b10, 5'd9, 5'd4, 5'd10, 1'b0, 1'b0));
    applyStimulus(mk(CTL_ADDU, 2'b10, 5'd9, 5'd4, 5'd10, 1'b0, 1'b1));
    checkOutput("flush_in_stall_sc_b", 32'(bus_b.stall_count), 32'd4);
    checkOutput("flush_in_stall_fc_b", 32'(bus_b.flush_count), 32'd1);

    applyStimulus(mk(CTL_LW, 2'b00, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0));
    applyStimulus(mk(CTL_ADDU, 2'b10, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0));
    applyStimulus(mk(CTL_ADDU, 2'b10, 5'd5, 5'd6, 5'd12, 1'b1, 1'b0));

    applyStimulus(mk(CTL_LW, 2'b00, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0));
    applyStimulus(mk(CTL_ADDU, 2'b10, 5'd9, 5'd4, 5'd10, 1'b0, 1'b0));
    doReset();

    for (int i = 0; i < 400; i++) begin
      s.ctl    = 8'($urandom);
      s.alu_op = 2'($urandom);
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.rd     = 5'($urandom);
      s.nop    = ($urandom_range(0, 15) == 0);
      s.flush  = ($urandom_range(0, 7) == 0);
      applyStimulus(s);
    end
    checkOutput("sat_flush_count_b", 32'(bus_b.flush_count), 32'(m_fcnt[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
